// File: rtl/alu_sequencer.sv
// Fetch/decode/execute/writeback controller for the 16-bit accumulator ALU.
// Owns W, the program counter and the carry/zero flags; runs from start until HALT.
module alu_sequencer #(
    parameter int PC_W = 8,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [PC_W-1:0] pc,
    input  logic [15:0]     instr,
    output logic [RA_W-1:0] rf_addr,
    input  logic [15:0]     rf_rdata,
    output logic [15:0]     rf_wdata,
    output logic            rf_we,
    output logic [3:0]      alu_inst,
    output logic [15:0]     alu_f,
    output logic [15:0]     alu_w,
    input  logic [16:0]     alu_ans,
    output logic [15:0]     w_reg,
    output logic            carry,
    output logic            zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_DONE
    } state_t;

    localparam logic [3:0] OP_NOP_ALU = 4'd8;
    localparam logic [3:0] OP_CLR     = 4'd9;
    localparam logic [3:0] OP_HALT    = 4'd15;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] instr_q;
    logic [16:0] ans_q;
    logic [15:0] alu_f_hold;
    logic [15:0] alu_w_hold;
    logic [3:0]  op_q;
    logic        dst_f;
    logic        wr_op;
    logic [15:0] result;
    logic        unused_rsvd;

    function automatic logic is_writing(input logic [3:0] op);
        return (op <= 4'd7) || (op == 4'd9) || (op == 4'd10);
    endfunction

    function automatic logic is_carry_op(input logic [3:0] op);
        return (op == 4'd2) || (op == 4'd3) || (op == 4'd5) || (op == 4'd6);
    endfunction

    assign op_q        = instr_q[15:12];
    assign dst_f       = instr_q[11];
    assign wr_op       = is_writing(op_q);
    assign result      = (op_q == OP_CLR) ? 16'h0000 : ans_q[15:0];
    // Reserved instruction bits are deliberately ignored.
    assign unused_rsvd = ^instr_q[10:RA_W];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = (instr[15:12] == OP_HALT) ? S_DONE : S_EXEC;
            S_EXEC:   state_nxt = S_WB;
            S_WB:     state_nxt = S_FETCH;
            S_DONE:   if (start) state_nxt = S_FETCH;
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign busy     = (state == S_FETCH) || (state == S_DECODE) ||
                      (state == S_EXEC)  || (state == S_WB);
    assign done     = (state == S_DONE);
    assign alu_inst = (state == S_EXEC) ? op_q : OP_NOP_ALU;
    assign alu_f    = (state == S_EXEC) ? rf_rdata : alu_f_hold;
    assign alu_w    = (state == S_EXEC) ? w_reg : alu_w_hold;
    assign rf_addr  = instr_q[RA_W-1:0];
    assign rf_wdata = result;
    assign rf_we    = (state == S_WB) && wr_op && dst_f;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            pc      <= '0;
            w_reg   <= 16'h0000;
            carry   <= 1'b0;
            zero    <= 1'b0;
            instr_q <= 16'h0000;
            ans_q   <= 17'h00000;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE, S_DONE: if (start) pc <= '0;
                S_DECODE:       instr_q <= instr;
                S_EXEC:         ans_q <= alu_ans;
                S_WB: begin
                    pc <= pc + PC_W'(1);
                    // NOP codes never touch W or flags: the ALU output is stale for them.
                    if (wr_op) begin
                        if (!dst_f) w_reg <= result;
                        zero <= (result == 16'h0000);
                    end
                    if (is_carry_op(op_q)) carry <= ans_q[16];
                end
                default: ;
            endcase
        end
    end

    // Operand hold registers keep the last EXEC operands visible outside EXEC.
    always_ff @(posedge clk) begin
        if (state == S_EXEC) begin
            alu_f_hold <= rf_rdata;
            alu_w_hold <= w_reg;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: program ROM, register file and ALU models,
// plus a PC_W=2 instance for the program-counter wrap case.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy, done;
    logic [7:0]  pc;
    logic [15:0] instr;
    logic [4:0]  rf_addr;
    logic [15:0] rf_rdata, rf_wdata;
    logic        rf_we;
    logic [3:0]  alu_inst;
    logic [15:0] alu_f, alu_w;
    logic [16:0] alu_ans;
    logic [16:0] alu_last;
    logic [15:0] w_reg;
    logic        carry, zero;

    logic        wstart = 1'b0;
    logic        wbusy, wdone;
    logic [1:0]  wpc;
    logic [15:0] winstr;
    logic [4:0]  wrf_addr;
    logic [15:0] wrf_wdata;
    logic        wrf_we;
    logic [3:0]  walu_inst;
    logic [15:0] walu_f, walu_w, ww_reg;
    logic        wcarry, wzero;
    logic [15:0] wrf_rdata = 16'h0000;
    logic [16:0] walu_ans = 17'h00000;

    logic [15:0] rom [256];
    logic [15:0] wrom [4];
    logic [15:0] rf [32];
    logic        ld_en = 1'b0;
    logic [4:0]  ld_a = 5'd0;
    logic [15:0] ld_d = 16'h0000;
    int          we_cnt = 0;
    int          we_snap;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.PC_W(8), .RA_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .pc(pc), .instr(instr), .rf_addr(rf_addr), .rf_rdata(rf_rdata),
        .rf_wdata(rf_wdata), .rf_we(rf_we), .alu_inst(alu_inst),
        .alu_f(alu_f), .alu_w(alu_w), .alu_ans(alu_ans), .w_reg(w_reg),
        .carry(carry), .zero(zero)
    );

    alu_sequencer #(.PC_W(2), .RA_W(5)) u_wrap (
        .clk(clk), .reset(reset), .start(wstart), .busy(wbusy), .done(wdone),
        .pc(wpc), .instr(winstr), .rf_addr(wrf_addr), .rf_rdata(wrf_rdata),
        .rf_wdata(wrf_wdata), .rf_we(wrf_we), .alu_inst(walu_inst),
        .alu_f(walu_f), .alu_w(walu_w), .alu_ans(walu_ans), .w_reg(ww_reg),
        .carry(wcarry), .zero(wzero)
    );

    // Synchronous ROMs: data valid the cycle after the address.
    always @(posedge clk) instr <= rom[pc];
    always @(posedge clk) winstr <= wrom[wpc];

    assign rf_rdata = rf[rf_addr];
    always @(posedge clk) begin
        if (ld_en) rf[ld_a] <= ld_d;
        else if (rf_we) rf[rf_addr] <= rf_wdata;
    end
    always @(posedge clk) if (rf_we) we_cnt <= we_cnt + 1;

    // ALU: 0 MOVF, 1 AND, 2 ADD, 3 W-F, 4 IOR, 5 F+1, 6 F-1, 7 XOR, 9 CLR, 10 COM.
    function automatic logic [16:0] alu_calc(input logic [3:0] op, input logic [15:0] f,
                                             input logic [15:0] w);
        case (op)
            4'd0:    return {1'b0, f};
            4'd1:    return {1'b0, w & f};
            4'd2:    return {1'b0, w} + {1'b0, f};
            4'd3:    return {1'b0, w} - {1'b0, f};
            4'd4:    return {1'b0, w | f};
            4'd5:    return {1'b0, f} + 17'd1;
            4'd6:    return {1'b0, f} - 17'd1;
            4'd7:    return {1'b0, w ^ f};
            4'd9:    return 17'd0;
            4'd10:   return {1'b0, ~f};
            default: return 17'd0;
        endcase
    endfunction

    function automatic logic alu_valid(input logic [3:0] op);
        return (op <= 4'd10) && (op != 4'd8);
    endfunction

    assign alu_ans = alu_valid(alu_inst) ? alu_calc(alu_inst, alu_f, alu_w) : alu_last;
    always @(posedge clk) if (alu_valid(alu_inst)) alu_last <= alu_ans;

    function automatic logic [15:0] ins(input logic [3:0] op, input logic d, input logic [4:0] a);
        return {op, d, 6'd0, a};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        while (!done && n < max) begin
            tick(1);
            n++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic load(input logic [4:0] a, input logic [15:0] d);
        ld_a = a;
        ld_d = d;
        ld_en = 1'b1;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
        wrom[0] = ins(4'd11, 1'b0, 5'd0);
        wrom[1] = ins(4'd12, 1'b1, 5'd1);
        wrom[2] = ins(4'd13, 1'b0, 5'd2);
        wrom[3] = ins(4'd14, 1'b1, 5'd3);
        #2;
        load(5'd1, 16'h0001);
        load(5'd2, 16'hFFFF);
        load(5'd3, 16'h0005);
        load(5'd4, 16'h1234);
        load(5'd5, 16'hAAAA);
        load(5'd6, 16'hEDCB);

        // Reset state
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pc", {24'd0, pc}, 32'd0);
        chk("rst_w", {16'd0, w_reg}, 32'd0);
        chk("rst_flags", {30'd0, carry, zero}, 32'd0);
        chk("rst_alu_inst", {28'd0, alu_inst}, 32'h8);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        reset = 1'b1;
        tick(1);

        // Reset during EXEC of ADDWF 3,d=1
        rom[0] = ins(4'd2, 1'b1, 5'd3);
        we_snap = we_cnt;
        start_pulse();
        tick(2);
        chk("exec_alu_inst", {28'd0, alu_inst}, 32'd2);
        chk("exec_alu_f", {16'd0, alu_f}, 32'h0005);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_pc", {24'd0, pc}, 32'd0);
        chk("abort_alu_inst", {28'd0, alu_inst}, 32'h8);
        chk("abort_rf_we", {31'd0, rf_we}, 32'd0);
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("abort_f3", {16'd0, rf[3]}, 32'h0005);
        chk("abort_we_cnt", we_cnt - we_snap, 32'd0);

        // Basic program: MOVF 3,0; INCF 3,1; ADDWF 3,0; HALT
        rom[0] = ins(4'd0, 1'b0, 5'd3);
        rom[1] = ins(4'd5, 1'b1, 5'd3);
        rom[2] = ins(4'd2, 1'b0, 5'd3);
        rom[3] = 16'hF000;
        we_snap = we_cnt;
        start_pulse();
        chk("basic_busy", {31'd0, busy}, 32'd1);
        tick(4);
        chk("basic_w_movf", {16'd0, w_reg}, 32'h0005);
        tick(3);
        chk("basic_rf_we", {31'd0, rf_we}, 32'd1);
        chk("basic_rf_wdata", {16'd0, rf_wdata}, 32'h0006);
        chk("basic_rf_addr", {27'd0, rf_addr}, 32'd3);
        tick(1);
        chk("basic_f3", {16'd0, rf[3]}, 32'h0006);
        chk("basic_rf_we_low", {31'd0, rf_we}, 32'd0);
        tick(4);
        chk("basic_w_add", {16'd0, w_reg}, 32'h000B);
        chk("basic_flags", {30'd0, carry, zero}, 32'd0);
        tick(1);
        chk("basic_done_13", {31'd0, done}, 32'd0);
        tick(1);
        chk("basic_done_14", {31'd0, done}, 32'd1);
        chk("basic_busy_done", {31'd0, busy}, 32'd0);
        chk("basic_pc_halt", {24'd0, pc}, 32'd3);
        chk("basic_we_cnt", we_cnt - we_snap, 32'd1);

        // Carry/borrow: MOVF 2,0 (W=FFFF); ADDWF 1,0; SUBWF 1,0; HALT
        rom[0] = ins(4'd0, 1'b0, 5'd2);
        rom[1] = ins(4'd2, 1'b0, 5'd1);
        rom[2] = ins(4'd3, 1'b0, 5'd1);
        rom[3] = 16'hF000;
        start_pulse();
        chk("restart_done", {31'd0, done}, 32'd0);
        chk("restart_pc", {24'd0, pc}, 32'd0);
        tick(4);
        chk("cy_w_ffff", {16'd0, w_reg}, 32'hFFFF);
        tick(4);
        chk("cy_add_w", {16'd0, w_reg}, 32'h0000);
        chk("cy_add_flags", {30'd0, carry, zero}, 32'd3);
        tick(4);
        chk("cy_sub_w", {16'd0, w_reg}, 32'hFFFF);
        chk("cy_sub_flags", {30'd0, carry, zero}, 32'd2);
        wait_done("cy_done", 10);

        // ANDWF to F giving 0, then NOP codes 8 and 12
        rom[0] = ins(4'd0, 1'b0, 5'd4);
        rom[1] = ins(4'd1, 1'b1, 5'd6);
        rom[2] = ins(4'd8, 1'b1, 5'd5);
        rom[3] = ins(4'd12, 1'b0, 5'd5);
        rom[4] = 16'hF000;
        we_snap = we_cnt;
        start_pulse();
        tick(4);
        chk("nop_w_movf", {16'd0, w_reg}, 32'h1234);
        chk("nop_carry_kept", {31'd0, carry}, 32'd1);
        tick(4);
        chk("and_f6", {16'd0, rf[6]}, 32'h0000);
        chk("and_flags", {30'd0, carry, zero}, 32'd3);
        chk("and_w_kept", {16'd0, w_reg}, 32'h1234);
        tick(6);
        chk("nop_exec_alu_inst", {28'd0, alu_inst}, 32'hC);
        wait_done("nop_done", 12);
        chk("nop_w", {16'd0, w_reg}, 32'h1234);
        chk("nop_flags", {30'd0, carry, zero}, 32'd3);
        chk("nop_f5", {16'd0, rf[5]}, 32'hAAAA);
        chk("nop_we_cnt", we_cnt - we_snap, 32'd1);
        chk("hold_alu_f", {16'd0, alu_f}, 32'hAAAA);
        chk("hold_alu_w", {16'd0, alu_w}, 32'h1234);
        chk("hold_alu_inst", {28'd0, alu_inst}, 32'h8);

        // start while busy is ignored; start held in DONE restarts
        rom[0] = ins(4'd11, 1'b0, 5'd0);
        rom[1] = ins(4'd13, 1'b0, 5'd0);
        rom[2] = 16'hF000;
        start_pulse();
        tick(4);
        chk("st_pc1", {24'd0, pc}, 32'd1);
        tick(2);
        start = 1'b1;
        tick(2);
        start = 1'b0;
        chk("st_ignored_pc", {24'd0, pc}, 32'd2);
        chk("st_ignored_busy", {31'd0, busy}, 32'd1);
        tick(2);
        chk("st_done", {31'd0, done}, 32'd1);
        chk("st_done_pc", {24'd0, pc}, 32'd2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("st_restart_done", {31'd0, done}, 32'd0);
        chk("st_restart_pc", {24'd0, pc}, 32'd0);
        chk("st_restart_busy", {31'd0, busy}, 32'd1);
        wait_done("st_rerun_done", 16);

        // PC wrap on the PC_W=2 instance
        wstart = 1'b1;
        tick(1);
        wstart = 1'b0;
        chk("wrap_pc0", {30'd0, wpc}, 32'd0);
        for (int i = 1; i <= 6; i++) begin
            tick(4);
            chk("wrap_pc", {30'd0, wpc}, i % 4);
            chk("wrap_busy", {31'd0, wbusy}, 32'd1);
        end
        chk("wrap_done", {31'd0, wdone}, 32'd0);
        chk("wrap_w", {16'd0, ww_reg}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
